// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and bit-reverse helper for the FFT reorder block
package fft_pkg;

  localparam int FFT_LOG2N      = 4;
  localparam int FFT_DATA_WIDTH = 5;

  // Reverses the low 'width' bits of value; bits above width return as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[i] = value[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_ram.sv
// rtl/reorder_ram.sv - two-bank sample store, one write port and one asynchronous read port
module reorder_ram
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int LOG2N      = FFT_LOG2N
) (
  input  logic                    i_clk,
  input  logic                    i_wr_en,
  input  logic [LOG2N:0]          i_wr_addr,
  input  logic [2*DATA_WIDTH-1:0] i_wr_data,
  input  logic [LOG2N:0]          i_rd_addr,
  output logic [2*DATA_WIDTH-1:0] o_rd_data
);

  localparam int DEPTH = 2**(LOG2N+1);

  logic [2*DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fft_reorder.sv
// rtl/fft_reorder.sv - ping-pong buffer turning bit-reversed FFT frames into natural order
module fft_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int LOG2N      = FFT_LOG2N
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_real,
  input  logic signed [DATA_WIDTH-1:0] in_imag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_real,
  output logic signed [DATA_WIDTH-1:0] out_imag,
  output logic [LOG2N-1:0]             out_index,
  output logic                         out_last
);

  localparam int              N    = 2**LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N-1);

  logic [1:0]                   r_full;
  logic                         r_wr_bank;
  logic                         r_rd_bank;
  logic [LOG2N-1:0]             r_wr_cnt;
  logic [LOG2N-1:0]             r_rd_cnt;
  logic                         r_out_valid;
  logic                         r_out_last;
  logic signed [DATA_WIDTH-1:0] r_out_real;
  logic signed [DATA_WIDTH-1:0] r_out_imag;
  logic [LOG2N-1:0]             r_out_index;

  logic                         w_in_hs;
  logic                         w_load;
  logic                         w_wr_last;
  logic                         w_rd_last;
  logic [LOG2N-1:0]             w_wr_addr;
  logic [2*DATA_WIDTH-1:0]      w_rd_data;
  logic [1:0]                   w_full_nxt;

  assign in_ready  = !r_full[r_wr_bank];
  assign w_in_hs   = in_valid && in_ready;
  assign w_load    = r_full[r_rd_bank] && (!r_out_valid || out_ready);
  assign w_wr_last = w_in_hs && (r_wr_cnt == LAST);
  assign w_rd_last = w_load && (r_rd_cnt == LAST);
  assign w_wr_addr = LOG2N'(bitrev(32'(r_wr_cnt), LOG2N));

  // Set and clear can land on the same edge; they always target different banks.
  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
  end

  reorder_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .LOG2N     (LOG2N)
  ) u_ram (
    .i_clk    (clk),
    .i_wr_en  (w_in_hs),
    .i_wr_addr({r_wr_bank, w_wr_addr}),
    .i_wr_data({in_real, in_imag}),
    .i_rd_addr({r_rd_bank, r_rd_cnt}),
    .o_rd_data(w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full      <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_real  <= '0;
      r_out_imag  <= '0;
      r_out_index <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_in_hs) begin
        r_wr_cnt <= r_wr_cnt + LOG2N'(1);
        if (w_wr_last) r_wr_bank <= !r_wr_bank;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_real  <= w_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
        r_out_imag  <= w_rd_data[DATA_WIDTH-1:0];
        r_out_index <= r_rd_cnt;
        r_out_last  <= (r_rd_cnt == LAST);
        r_rd_cnt    <= r_rd_cnt + LOG2N'(1);
        if (w_rd_last) r_rd_bank <= !r_rd_bank;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_real  = r_out_real;
  assign out_imag  = r_out_imag;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_fft_reorder.sv
// tb/tb_fft_reorder.sv - randomized self-checking bench for fft_reorder against a frame-level model
module tb_fft_reorder;

  localparam int DW = 5;
  localparam int LG = 4;
  localparam int N  = 16;

  logic                 clk       = 1'b0;
  logic                 rst       = 1'b1;
  logic                 in_valid  = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_real   = '0;
  logic signed [DW-1:0] in_imag   = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] out_real;
  logic signed [DW-1:0] out_imag;
  logic [LG-1:0]        out_index;
  logic                 out_last;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rdy_pct  = 0;

  typedef struct {
    int re;
    int im;
    int idx;
  } samp_t;

  samp_t exp_q[$];
  int    fr_re[N];
  int    fr_im[N];
  int    fr_cnt       = 0;
  int    out_cnt      = 0;
  int    stall_cnt    = 0;
  int    gap_cnt      = 0;
  int    prev_out_cyc = 0;
  bit    ob_first     = 1'b1;
  int    c0;

  fft_reorder #(.DATA_WIDTH(DW), .LOG2N(LG)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_real  (in_real),
    .in_imag  (in_imag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_real (out_real),
    .out_imag (out_imag),
    .out_index(out_index),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    out_ready = ($urandom_range(99) < rdy_pct);
  end

  function automatic int rev4(int k);
    int r = 0;
    for (int b = 0; b < LG; b++)
      if ((k & (1 << b)) != 0) r |= 1 << (LG - 1 - b);
    return r;
  endfunction

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Frame-level model: collect a whole frame, then emit it sorted by natural index.
  always @(negedge clk) begin
    samp_t s;
    if (rst) begin
      exp_q.delete();
      fr_cnt = 0;
    end else begin
      if (in_valid && !in_ready) stall_cnt++;
      if (in_valid && in_ready) begin
        fr_re[fr_cnt] = int'(in_real);
        fr_im[fr_cnt] = int'(in_imag);
        fr_cnt++;
        if (fr_cnt == N) begin
          for (int j = 0; j < N; j++) begin
            s.re  = fr_re[rev4(j)];
            s.im  = fr_im[rev4(j)];
            s.idx = j;
            exp_q.push_back(s);
          end
          fr_cnt = 0;
        end
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (!ob_first && cyc != prev_out_cyc + 1) gap_cnt++;
        ob_first     = 1'b0;
        prev_out_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          s = exp_q.pop_front();
          chk("out_real",  int'(out_real),  s.re);
          chk("out_imag",  int'(out_imag),  s.im);
          chk("out_index", int'(out_index), s.idx);
          chk("out_last",  int'(out_last),  (s.idx == N - 1) ? 1 : 0);
        end
      end
    end
  end

  task automatic send(input int n, input int pct, input bit pattern);
    int sent  = 0;
    int guard = 0;
    bit hs;
    int r;
    while (sent < n && guard < 5000) begin
      if ($urandom_range(99) < pct) begin
        in_valid = 1'b1;
        if (pattern) begin
          r       = rev4(sent % N);
          in_real = DW'(r);
          in_imag = DW'(-r);
        end else begin
          in_real = DW'($urandom);
          in_imag = DW'($urandom);
        end
      end else begin
        in_valid = 1'b0;
      end
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) sent++;
      guard++;
    end
    in_valid = 1'b0;
    if (sent < n) chk("send_timeout", sent, n);
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_in_time", (g < 3000) ? 1 : 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_out_last",  int'(out_last),  0);
    chk("rst_out_index", int'(out_index), 0);
    chk("rst_out_real",  int'(out_real),  0);
    chk("rst_out_imag",  int'(out_imag),  0);

    // single frame, latency of the first output
    rdy_pct = 100;
    repeat (2) @(posedge clk);
    #1;
    c0 = out_cnt;
    send(16, 100, 1'b1);
    chk("lat_before", int'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_valid", int'(out_valid), 1);
    chk("lat_index", int'(out_index), 0);
    wait_drain();
    chk("single_count", out_cnt - c0, 16);

    // back-to-back frames, including coincident bank set/clear
    c0        = out_cnt;
    stall_cnt = 0;
    gap_cnt   = 0;
    ob_first  = 1'b1;
    send(64, 100, 1'b0);
    wait_drain();
    chk("b2b_stalls", stall_cnt, 0);
    chk("b2b_gaps",   gap_cnt,   0);
    chk("b2b_count",  out_cnt - c0, 64);

    // backpressure: both banks fill and the first output is held
    rdy_pct = 0;
    repeat (2) @(posedge clk);
    #1;
    c0 = out_cnt;
    send(32, 100, 1'b0);
    chk("bp_in_ready_low", int'(in_ready),  0);
    chk("bp_out_valid",    int'(out_valid), 1);
    chk("bp_index0",       int'(out_index), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_hold_index", int'(out_index), 0);
    chk("bp_hold_valid", int'(out_valid), 1);
    chk("bp_hold_real",  int'(out_real), (exp_q.size() > 0) ? exp_q[0].re : 999);
    chk("bp_hold_imag",  int'(out_imag), (exp_q.size() > 0) ? exp_q[0].im : 999);
    chk("bp_in_ready_held", int'(in_ready), 0);
    rdy_pct = 100;
    wait_drain();
    chk("bp_count",        out_cnt - c0, 32);
    chk("bp_in_ready_end", int'(in_ready), 1);

    // random stalls on both sides over 10 frames
    rdy_pct = 50;
    c0 = out_cnt;
    send(160, 50, 1'b0);
    wait_drain();
    chk("rand_count",   out_cnt - c0, 160);
    chk("rand_partial", fr_cnt, 0);

    // reset in the middle of a frame
    rdy_pct = 100;
    repeat (2) @(posedge clk);
    #1;
    send(7, 100, 1'b0);
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready",  int'(in_ready),  1);
    c0 = out_cnt;
    send(16, 100, 1'b1);
    wait_drain();
    chk("mid_rst_count", out_cnt - c0, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
